// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// the most negative 32-bit value and the execute-stage ALU opcodes.
package multdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam logic [4:0] ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

    function automatic logic is_busy_state(input logic [1:0] state);
        return (state == ST_MUL) || (state == ST_DIV);
    endfunction

endpackage

// File: rtl/multdiv_iterative_if.sv
// Operand/strobe/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface multdiv_iterative_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_iterative_div_step.sv
// One non-restoring division iteration on unsigned magnitudes: shift {R, Q}
// left, add or subtract the divisor depending on the old sign of R.
module nonrestoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH+1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] rem_shifted;
    logic [WIDTH+1:0] divisor_ext;

    // R stays within two extra bits of headroom, so the dropped top bit is
    // always a copy of the sign and the shift cannot lose information.
    always_comb begin
        rem_shifted = {rem_in[WIDTH:0], quo_in[WIDTH-1]};
        divisor_ext = {2'b00, divisor};
        if (rem_in[WIDTH+1]) begin
            rem_out = rem_shifted + divisor_ext;
        end else begin
            rem_out = rem_shifted - divisor_ext;
        end
        quo_out = {quo_in[WIDTH-2:0], ~rem_out[WIDTH+1]};
    end

endmodule

// File: rtl/multdiv_iterative.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) unit
// with a fixed WIDTH-iteration latency, one DONE cycle and restart-on-strobe.
module multdiv_iterative
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic              clock,
    input logic              reset,
    multdiv_iterative_if.slave bus
);

    localparam int PW = 2 * WIDTH + 2;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    prod;
    logic [WIDTH+1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   prod_hi;
    logic [WIDTH:0]   hi_sum;
    logic [PW-1:0]    prod_next;
    logic             mul_ovf;
    logic [WIDTH+1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_signed;

    // Product register layout: {upper WIDTH+1, lower WIDTH, Booth bit}. The
    // extra upper bit lets INT_MIN be subtracted without overflowing.
    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        prod_hi   = prod[PW-1 -: WIDTH+1];
        case (prod[1:0])
            2'b01:   hi_sum = prod_hi + mcand_ext;
            2'b10:   hi_sum = prod_hi - mcand_ext;
            default: hi_sum = prod_hi;
        endcase
        prod_next = {hi_sum[WIDTH], hi_sum, prod[WIDTH:1]};
        mul_ovf   = (prod_next[2*WIDTH:WIDTH+1] != {WIDTH{prod_next[WIDTH]}});
    end

    nonrestoring_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    assign quo_signed = neg_q ? (-quo_next) : quo_next;

    // A new strobe always wins over the current state, which gives abort in
    // MUL/DIV and back-to-back acceptance in DONE with a single rule.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            mcand    <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            mcand <= bus.data_operandA;
            prod  <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
            count <= '0;
            state <= ST_MUL;
        end else if (bus.ctrl_DIV) begin
            quo      <= bus.data_operandA[WIDTH-1] ? (-bus.data_operandA) : bus.data_operandA;
            divisor  <= bus.data_operandB[WIDTH-1] ? (-bus.data_operandB) : bus.data_operandB;
            rem      <= '0;
            neg_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_zero <= (bus.data_operandB == '0);
            div_ovf  <= (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
            count    <= '0;
            state    <= ST_DIV;
        end else begin
            case (state)
                ST_MUL: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        result_q <= prod_next[WIDTH:1];
                        exc_q    <= mul_ovf;
                        state    <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        result_q <= div_zero ? '0 : quo_signed;
                        exc_q    <= div_zero | div_ovf;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == ST_DONE);
    assign bus.busy           = is_busy_state(state);

endmodule

// File: tb/tb_multdiv_iterative.sv
// Bench for multdiv_iterative: directed operations checked against literals,
// plus a per-cycle compare against an arithmetic model of result timing.
module tb_multdiv_iterative;
    import multdiv_pkg::*;

    logic clock;
    logic reset;
    int   cyc;
    int   passed;
    int   total_checks;

    // Model of the pending operation and of the held outputs.
    logic        pend_valid;
    int          pend_due;
    logic [31:0] pend_res;
    logic        pend_exc;
    logic [31:0] last_res;
    logic        last_exc;
    logic        exp_rdy;
    logic        exp_busy;
    int          issue_cyc;
    int          latency;
    logic        got_rdy;

    multdiv_iterative_if #(.WIDTH(32)) bus ();

    multdiv_iterative #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        return {(p != longint'($signed(lo))), lo};
    endfunction

    function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Per-cycle compare: RDY exactly 32 edges after acceptance, busy before it.
    always @(negedge clock) begin
        exp_rdy  = pend_valid && (cyc == pend_due);
        exp_busy = pend_valid && (cyc < pend_due);
        if (exp_rdy) begin
            last_res   = pend_res;
            last_exc   = pend_exc;
            pend_valid = 1'b0;
        end
        check("cyc_rdy", 64'(bus.data_resultRDY), 64'(exp_rdy));
        check("cyc_busy", 64'(bus.busy), 64'(exp_busy));
        check("cyc_result", 64'(bus.data_result), 64'(last_res));
        check("cyc_exception", 64'(bus.data_exception), 64'(last_exc));
    end

    task automatic apply_stimulus(input logic mult, input logic div,
                                  input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mult;
        bus.ctrl_DIV      = div;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = a ^ 32'h5A5A_A5A5;
        bus.data_operandB = b ^ 32'hC3C3_3C3C;
        issue_cyc = cyc;
        e = mult ? model_mult(a, b) : model_div(a, b);
        pend_valid = 1'b1;
        pend_due   = cyc + 32;
        pend_res   = e[31:0];
        pend_exc   = e[32];
    endtask

    task automatic check_output(input string name, input logic [31:0] exp_res, input logic exp_exc);
        got_rdy = 1'b0;
        for (int i = 0; i < 40 && !got_rdy; i++) begin
            @(negedge clock);
            got_rdy = bus.data_resultRDY;
        end
        if (!got_rdy) begin
            check({name, "_rdy_timeout"}, 64'd0, 64'd1);
        end else begin
            latency = cyc - issue_cyc + 1;
            check({name, "_result"}, 64'(bus.data_result), 64'(exp_res));
            check({name, "_exception"}, 64'(bus.data_exception), 64'(exp_exc));
            check({name, "_latency"}, 64'(latency), 64'd33);
        end
    endtask

    task automatic run_op(input string name, input logic mult, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        apply_stimulus(mult, div, a, b);
        check_output(name, exp_res, exp_exc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        cyc = 0; passed = 0; total_checks = 0;
        pend_valid = 1'b0; pend_due = 0; pend_res = '0; pend_exc = 1'b0;
        last_res = '0; last_exc = 1'b0;
        bus.data_operandA = '0; bus.data_operandB = '0;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        reset = 1'b0;

        // Literal pins on the model itself.
        check("model_mult_7x-3", 64'(model_mult(32'd7, 32'hFFFF_FFFD)), 64'({1'b0, 32'hFFFF_FFEB}));
        check("model_mult_ovf", 64'(model_mult(32'h0001_0000, 32'h0001_0000)), 64'({1'b1, 32'h0}));
        check("model_div_-7/2", 64'(model_div(32'hFFFF_FFF9, 32'd2)), 64'({1'b0, 32'hFFFF_FFFD}));
        check("model_div_100/-7", 64'(model_div(32'd100, 32'hFFFF_FFF9)), 64'({1'b0, 32'hFFFF_FFF2}));

        repeat (3) @(negedge clock);
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_exception", 64'(bus.data_exception), 64'd0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        @(posedge clock); #3; reset = 1'b1;

        run_op("mul_basic", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1);
        run_op("mul_min_x_-1", 1, 0, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("mul_-1_x_-1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
        run_op("div_-100/-7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0);
        run_op("div_min/-1", 0, 1, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("div_by_zero", 0, 1, 32'd5, 32'd0, 32'd0, 1);
        run_op("div_0/7", 0, 1, 32'd0, 32'd7, 32'd0, 0);
        run_op("div_min/1", 0, 1, INT_MIN, 32'd1, 32'h8000_0000, 0);

        // Abort a divide with a multiply ten cycles in.
        apply_stimulus(0, 1, 32'd50, 32'd5);
        repeat (9) @(negedge clock);
        run_op("restart_mul", 1, 0, 32'd3, 32'd4, 32'd12, 0);

        run_op("both_strobes", 1, 1, 32'd6, 32'd3, 32'd18, 0);

        // Asynchronous reset in the middle of a multiply.
        apply_stimulus(1, 0, 32'd123, 32'd456);
        repeat (19) @(negedge clock);
        @(posedge clock); #3;
        reset = 1'b0;
        pend_valid = 1'b0; last_res = '0; last_exc = 1'b0;
        #1;
        check("midreset_result", 64'(bus.data_result), 64'd0);
        check("midreset_exception", 64'(bus.data_exception), 64'd0);
        check("midreset_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clock);
        @(posedge clock); #3; reset = 1'b1;
        repeat (40) @(negedge clock);
        run_op("after_reset", 1, 0, 32'd9, 32'd9, 32'd81, 0);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
